// File: rtl/multiplexor_display.sv
// 4-digit common-anode 7-segment scanner.
// Runs a self-timed slot counter, latches the display inputs once per frame,
// blanks the start of each slot against ghosting and can hide leading zeros.
module multiplexor_display #(
  parameter int unsigned CUENTA_MAX = 208332,
  parameter int unsigned BLANCO     = 1000,
  parameter int unsigned ANCHO      = 18
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] dato,
  input  logic [3:0]  habilitar,
  input  logic [3:0]  puntos,
  input  logic        suprimir_ceros,
  output logic [3:0]  anodos,
  output logic [6:0]  segmentos,
  output logic        punto,
  output logic        fin_cuadro
);

  localparam logic [ANCHO-1:0] CUENTA_FIN = ANCHO'(CUENTA_MAX);
  localparam logic [ANCHO-1:0] BLANCO_FIN = ANCHO'(BLANCO);
  localparam logic [ANCHO-1:0] UNO        = {{(ANCHO-1){1'b0}}, 1'b1};

  // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
  function automatic logic [6:0] decode_hex(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      4'hF:    seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

  logic [ANCHO-1:0] cuenta_q, cuenta_d;
  logic [1:0]       digito_q, digito_d;
  logic [15:0]      dato_sh_q, dato_sh_d;
  logic [3:0]       habilitar_sh_q, habilitar_sh_d;
  logic [3:0]       puntos_sh_q, puntos_sh_d;
  logic             suprimir_sh_q, suprimir_sh_d;
  logic [3:0]       anodos_q, anodos_d;
  logic [6:0]       segmentos_q, segmentos_d;
  logic             punto_q, punto_d;
  logic             fin_cuadro_q, fin_cuadro_d;

  logic             fin_slot_s;
  logic             latch_s;
  logic [3:0]       nibble_s;
  logic [3:0]       sup_s;
  logic             anodo_on_s;

  // Slot counter, digit index and frame-synchronous shadow capture.
  always_comb begin
    fin_slot_s     = (cuenta_q == CUENTA_FIN);
    latch_s        = fin_slot_s && (digito_q == 2'd3);
    cuenta_d       = cuenta_q + UNO;
    digito_d       = digito_q;
    dato_sh_d      = dato_sh_q;
    habilitar_sh_d = habilitar_sh_q;
    puntos_sh_d    = puntos_sh_q;
    suprimir_sh_d  = suprimir_sh_q;
    fin_cuadro_d   = 1'b0;
    if (fin_slot_s) begin
      cuenta_d = {ANCHO{1'b0}};
      digito_d = digito_q + 2'd1;
    end else begin
      cuenta_d = cuenta_q + UNO;
      digito_d = digito_q;
    end
    if (latch_s) begin
      dato_sh_d      = dato;
      habilitar_sh_d = habilitar;
      puntos_sh_d    = puntos;
      suprimir_sh_d  = suprimir_ceros;
      fin_cuadro_d   = 1'b1;
    end else begin
      fin_cuadro_d   = 1'b0;
    end
  end

  // Pin values for the current slot, from pre-edge counter state and shadows.
  always_comb begin
    nibble_s    = 4'h0;
    sup_s       = 4'b0000;
    anodo_on_s  = 1'b0;
    anodos_d    = 4'hF;
    segmentos_d = 7'h7F;
    punto_d     = 1'b1;
    case (digito_q)
      2'd0:    nibble_s = dato_sh_q[3:0];
      2'd1:    nibble_s = dato_sh_q[7:4];
      2'd2:    nibble_s = dato_sh_q[11:8];
      2'd3:    nibble_s = dato_sh_q[15:12];
      default: nibble_s = 4'h0;
    endcase
    // A digit is a leading zero only if it and every digit above it are zero.
    if (suprimir_sh_q) begin
      sup_s[3] = (dato_sh_q[15:12] == 4'h0);
      sup_s[2] = sup_s[3] && (dato_sh_q[11:8] == 4'h0);
      sup_s[1] = sup_s[2] && (dato_sh_q[7:4] == 4'h0);
      sup_s[0] = 1'b0;
    end else begin
      sup_s = 4'b0000;
    end
    // A requested decimal point keeps a suppressed digit's anode on.
    anodo_on_s = habilitar_sh_q[digito_q] && (!sup_s[digito_q] || puntos_sh_q[digito_q]);
    if (cuenta_q < BLANCO_FIN) begin
      anodos_d    = 4'hF;
      segmentos_d = 7'h7F;
      punto_d     = 1'b1;
    end else begin
      anodos_d    = anodo_on_s ? ~(4'b0001 << digito_q) : 4'hF;
      segmentos_d = (anodo_on_s && !sup_s[digito_q]) ? decode_hex(nibble_s) : 7'h7F;
      punto_d     = !(anodo_on_s && puntos_sh_q[digito_q]);
    end
  end

  // State and registered outputs; reset restarts at digit 0 slot start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cuenta_q       <= {ANCHO{1'b0}};
      digito_q       <= 2'd0;
      dato_sh_q      <= dato;
      habilitar_sh_q <= habilitar;
      puntos_sh_q    <= puntos;
      suprimir_sh_q  <= suprimir_ceros;
      anodos_q       <= 4'hF;
      segmentos_q    <= 7'h7F;
      punto_q        <= 1'b1;
      fin_cuadro_q   <= 1'b0;
    end else begin
      cuenta_q       <= cuenta_d;
      digito_q       <= digito_d;
      dato_sh_q      <= dato_sh_d;
      habilitar_sh_q <= habilitar_sh_d;
      puntos_sh_q    <= puntos_sh_d;
      suprimir_sh_q  <= suprimir_sh_d;
      anodos_q       <= anodos_d;
      segmentos_q    <= segmentos_d;
      punto_q        <= punto_d;
      fin_cuadro_q   <= fin_cuadro_d;
    end
  end

  assign anodos     = anodos_q;
  assign segmentos  = segmentos_q;
  assign punto      = punto_q;
  assign fin_cuadro = fin_cuadro_q;

endmodule

// File: tb/tb_multiplexor_display.sv
// Directed bench for multiplexor_display with CUENTA_MAX=9, BLANCO=2.
module tb_multiplexor_display;

  logic        clk;
  logic        rst_n;
  logic [15:0] dato;
  logic [3:0]  habilitar;
  logic [3:0]  puntos;
  logic        suprimir_ceros;
  logic [3:0]  anodos;
  logic [6:0]  segmentos;
  logic        punto;
  logic        fin_cuadro;

  int total_cnt;
  int bad_cnt;
  int edge_n;

  multiplexor_display #(
    .CUENTA_MAX(9),
    .BLANCO    (2),
    .ANCHO     (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .dato          (dato),
    .habilitar     (habilitar),
    .puntos        (puntos),
    .suprimir_ceros(suprimir_ceros),
    .anodos        (anodos),
    .segmentos     (segmentos),
    .punto         (punto),
    .fin_cuadro    (fin_cuadro)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s edge=%0d got=%h exp=%h", tag, edge_n, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold reset with the given inputs for two edges, check reset pins, release.
  task automatic reset_with(input logic [15:0] d, input logic [3:0] h,
                            input logic [3:0] p, input logic s);
    rst_n          = 1'b0;
    dato           = d;
    habilitar      = h;
    puntos         = p;
    suprimir_ceros = s;
    tick();
    tick();
    check_val("rst_an",  {12'h0, anodos}, 16'h000F);
    check_val("rst_seg", {9'h0, segmentos}, 16'h007F);
    check_val("rst_dp",  {15'h0, punto}, 16'h0001);
    check_val("rst_fin", {15'h0, fin_cuadro}, 16'h0000);
    rst_n  = 1'b1;
    edge_n = 0;
  endtask

  // Run n edges; segs = {d3,d2,d1,d0} codes, lit = digits whose anode goes low,
  // dp = digits whose point is lit. Slot is 10 edges, blank for first 2.
  task automatic run_scan(input int n, input logic [27:0] segs,
                          input logic [3:0] lit, input logic [3:0] dp);
    int          d;
    logic        blank;
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;
    logic        exp_dp;
    logic        exp_fin;
    for (int k = 0; k < n; k++) begin
      tick();
      edge_n++;
      d       = ((edge_n - 1) / 10) % 4;
      blank   = (((edge_n - 1) % 10) < 2);
      exp_fin = ((edge_n % 40) == 0);
      if (blank || !lit[d]) begin
        exp_an  = 4'hF;
        exp_seg = 7'h7F;
        exp_dp  = 1'b1;
      end else begin
        exp_an     = 4'hF;
        exp_an[d]  = 1'b0;
        exp_seg    = segs[d*7 +: 7];
        exp_dp     = !dp[d];
      end
      check_val("anodos", {12'h0, anodos}, {12'h0, exp_an});
      check_val("segmentos", {9'h0, segmentos}, {9'h0, exp_seg});
      check_val("punto", {15'h0, punto}, {15'h0, exp_dp});
      check_val("fin_cuadro", {15'h0, fin_cuadro}, {15'h0, exp_fin});
      check_val("one_anode", 16'($countones(~anodos) <= 1), 16'h0001);
    end
  endtask

  localparam logic [27:0] SEG_1234 = {7'h79, 7'h24, 7'h30, 7'h19};
  localparam logic [27:0] SEG_ABCD = {7'h08, 7'h03, 7'h46, 7'h21};

  initial begin
    total_cnt      = 0;
    bad_cnt        = 0;
    edge_n         = 0;
    rst_n          = 1'b0;
    dato           = 16'h0;
    habilitar      = 4'h0;
    puntos         = 4'h0;
    suprimir_ceros = 1'b0;

    // Basic scan and frame latch: new data at edge 15 appears only after edge 40.
    reset_with(16'h1234, 4'hF, 4'h0, 1'b0);
    run_scan(15, SEG_1234, 4'hF, 4'h0);
    dato = 16'hABCD;
    run_scan(25, SEG_1234, 4'hF, 4'h0);
    run_scan(40, SEG_ABCD, 4'hF, 4'h0);

    // Leading-zero suppression.
    reset_with(16'h0050, 4'hF, 4'h0, 1'b1);
    run_scan(40, {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'b0011, 4'h0);
    reset_with(16'h0000, 4'hF, 4'h0, 1'b1);
    run_scan(40, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b0001, 4'h0);

    // Enables and points: digit 2 disabled, its point request ignored.
    reset_with(16'h1234, 4'b1011, 4'b0101, 1'b0);
    run_scan(40, {7'h79, 7'h7F, 7'h30, 7'h19}, 4'b1011, 4'b0001);

    // A point keeps a suppressed digit's anode on with blank segments.
    reset_with(16'h0000, 4'hF, 4'b0100, 1'b1);
    run_scan(40, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b0101, 4'b0100);

    // Reset mid-operation at edge 25, then identical restart.
    reset_with(16'h1234, 4'hF, 4'h0, 1'b0);
    run_scan(24, SEG_1234, 4'hF, 4'h0);
    rst_n = 1'b0;
    tick();
    check_val("mid_rst_an",  {12'h0, anodos}, 16'h000F);
    check_val("mid_rst_seg", {9'h0, segmentos}, 16'h007F);
    check_val("mid_rst_dp",  {15'h0, punto}, 16'h0001);
    check_val("mid_rst_fin", {15'h0, fin_cuadro}, 16'h0000);
    rst_n  = 1'b1;
    edge_n = 0;
    run_scan(40, SEG_1234, 4'hF, 4'h0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
